// File: rtl/q_pipe_sched.sv
// rtl/q_pipe_sched.sv - two-source round-robin token scheduler for a two-phase q_2step pipeline
module q_pipe_sched #(
    parameter int MAX_INFLIGHT = 5,
    parameter int TAG_DEPTH    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       req0,
    input  logic       req1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       r_in,
    input  logic       a_in,
    input  logic       r_out,
    output logic       a_out,
    output logic       done0,
    output logic       done1,
    output logic [3:0] inflight,
    output logic       err
);

    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = $clog2(TAG_DEPTH + 1);
    localparam logic [3:0]    MAX_CNT  = 4'(MAX_INFLIGHT);
    localparam logic [PW-1:0] LAST_PTR = PW'(TAG_DEPTH - 1);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic          r_a_in_s1;
    logic          r_a_in_s;
    logic          r_r_out_s1;
    logic          r_r_out_s;
    logic          r_req_in;
    logic          r_a_out;
    logic          r_gnt0;
    logic          r_gnt1;
    logic          r_done0;
    logic          r_done1;
    logic          r_err;
    logic          r_last;
    logic [3:0]    r_inflight;
    logic          r_tag_mem [TAG_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_inject;
    logic w_src;
    logic w_complete;
    logic w_pop;
    logic w_tag;

    // Two-flop synchronizers for the asynchronous pipeline handshake inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_in_s1  <= 1'b0;
            r_a_in_s   <= 1'b0;
            r_r_out_s1 <= 1'b0;
            r_r_out_s  <= 1'b0;
        end else begin
            r_a_in_s1  <= a_in;
            r_a_in_s   <= r_a_in_s1;
            r_r_out_s1 <= r_out;
            r_r_out_s  <= r_r_out_s1;
        end
    end

    // Head FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Head FSM next state, injection decision and round-robin source pick
    always_comb begin
        w_state_nxt = r_state;
        w_inject    = 1'b0;
        w_src       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && (r_inflight < MAX_CNT) && (req0 || req1)) begin
                    w_inject    = 1'b1;
                    w_state_nxt = WAIT_ACK;
                    // Both requesting: the source not served last wins
                    w_src = (req0 && req1) ? ~r_last : req1;
                end
            end
            WAIT_ACK: begin
                if (r_a_in_s == r_req_in) begin
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    // Tail side: a pending tail request is serviced every cycle it is seen
    always_comb begin
        w_complete = (r_r_out_s != r_a_out);
        w_pop      = w_complete && (r_count != '0);
        w_tag      = r_tag_mem[r_rd_ptr];
    end

    // Handshake toggles, one-cycle pulses, sticky error and arbitration pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_in <= 1'b0;
            r_a_out  <= 1'b0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_err    <= 1'b0;
            r_last   <= 1'b1;
        end else begin
            r_gnt0  <= w_inject && !w_src;
            r_gnt1  <= w_inject && w_src;
            r_done0 <= w_pop && !w_tag;
            r_done1 <= w_pop && w_tag;
            if (w_inject) begin
                r_req_in <= ~r_req_in;
                r_last   <= w_src;
            end
            if (w_complete) begin
                r_a_out <= ~r_a_out;
            end
            if (w_complete && !w_pop) begin
                r_err <= 1'b1;
            end
        end
    end

    // In-flight counter and tag FIFO pointers; a tail request on an empty FIFO pops nothing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 4'd0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            case ({w_inject, w_pop})
                2'b10: begin
                    r_inflight <= r_inflight + 4'd1;
                    r_count    <= r_count + 1'b1;
                end
                2'b01: begin
                    r_inflight <= r_inflight - 4'd1;
                    r_count    <= r_count - 1'b1;
                end
                default: begin
                    r_inflight <= r_inflight;
                    r_count    <= r_count;
                end
            endcase
            if (w_inject) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    // Tag storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (w_inject) begin
            r_tag_mem[r_wr_ptr] <= w_src;
        end
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign r_in     = r_req_in;
    assign a_out    = r_a_out;
    assign done0    = r_done0;
    assign done1    = r_done1;
    assign inflight = r_inflight;
    assign err      = r_err;

endmodule

// File: doc/q_pipe_sched.md
Q_PIPE_SCHED -- requirements
Module: q_pipe_sched

Interface
REQ-001 Parameter MAX_INFLIGHT, default 5; maximum tokens resident in the attached q_2step pipeline (one per stage).
REQ-002 Parameter TAG_DEPTH, default 8; source-tag FIFO depth, SHALL be at least MAX_INFLIGHT.
REQ-003 clk  in  1  single system clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high; also drives the pipeline stages' rst.
REQ-005 start  in  1  issue enable; low blocks new injections, completions still serviced.
REQ-006 req0  in  1  level request from source 0.
REQ-007 req1  in  1  level request from source 1.
REQ-008 gnt0  out  1  one-cycle pulse: token injected for source 0.
REQ-009 gnt1  out  1  one-cycle pulse: token injected for source 1.
REQ-010 r_in  out  1  two-phase request to pipeline head; each toggle injects one token.
REQ-011 a_in  in  1  two-phase acknowledge from pipeline head (asynchronous).
REQ-012 r_out  in  1  two-phase request from pipeline tail (asynchronous).
REQ-013 a_out  out  1  two-phase acknowledge to pipeline tail.
REQ-014 done0  out  1  one-cycle pulse: source-0 token left the tail.
REQ-015 done1  out  1  one-cycle pulse: source-1 token left the tail.
REQ-016 inflight  out  4  count of injected, not yet completed tokens.
REQ-017 err  out  1  sticky flag: tail request with empty tag FIFO.

Function
REQ-018 a_in and r_out SHALL each pass a 2-flop synchronizer (a_in_s, r_out_s) before any use.
REQ-019 Head FSM states: IDLE, WAIT_ACK.
REQ-020 IDLE -> WAIT_ACK when start=1, inflight<MAX_INFLIGHT, and (req0|req1): on that edge r_in toggles, selected gnt pulses, source ID pushed to tag FIFO.
REQ-021 WAIT_ACK -> IDLE on the first edge where a_in_s==r_in; no injection on that edge; earliest next injection one cycle later.
REQ-022 Arbitration round-robin: both requesting -> grant the source not granted last; pointer updates only on a grant; after reset source 0 has priority.
REQ-023 gnt0 and gnt1 SHALL never be high together; at most one gnt per two cycles.
REQ-024 Tail: on an edge where r_out_s!=a_out, a_out toggles, tag FIFO pops, done0 or done1 pulses per popped tag.
REQ-025 Completion latency: done pulse and a_out toggle visible 3 rising edges after r_out toggles (2 sync + 1 register).
REQ-026 inflight +1 per injection, -1 per completion; simultaneous injection and completion -> unchanged; SHALL never exceed MAX_INFLIGHT.
REQ-027 inflight==MAX_INFLIGHT: requests held off (no gnt) until a completion; injection allowed on the edge after that completion.
REQ-028 Tail request with empty tag FIFO: a_out still toggles, no done pulse, inflight unchanged (no underflow), err set to 1.
REQ-029 Tag FIFO wrap-around: pointers modulo TAG_DEPTH; order of done pulses SHALL equal order of gnts.
REQ-030 start falling during WAIT_ACK: current handshake completes normally; no further gnts.
REQ-031 Requests deasserted before the edge are not granted; no request memory.

Reset
REQ-032 While rst=1: r_in=0, a_out=0, gnt0=gnt1=0, done0=done1=0, inflight=0, err=0, FSM=IDLE, tag FIFO empty, synchronizers 0, round-robin favours source 0.
REQ-033 rst asserted mid-operation clears all state immediately; in-flight tokens discarded without done pulses.
REQ-034 First injection permitted on the first edge after rst deasserts, given start=1 and a request.

Verification
REQ-035 Five q_2step stages, tail loopback via controller, start=1, req0=1 only -> gnt0 pulses with r_in toggling; inflight saturates at 5; done0 count equals gnt0 count; err=0.
REQ-036 req0=req1=1 continuous -> gnt sequence 0,1,0,1...; done sequence identical, including across FIFO wrap (>=20 tokens).
REQ-037 Pipeline tail stalled, inflight=5 -> no gnt; release one tail handshake -> done pulse, inflight=4, gnt on next eligible edge.
REQ-038 Forced r_out toggle after reset with nothing issued -> a_out toggles 3 edges later, err=1, inflight=0, no done pulse.
REQ-039 rst pulsed with inflight=3 -> all outputs to reset values within the rst pulse; after release, req1 alone -> gnt1 on first edge, inflight=1.
REQ-040 start lowered during WAIT_ACK -> handshake completes (a_in_s==r_in, FSM IDLE), no further gnts, pending completions still produce done pulses.
